unsigned_seq_array_multiplier: RTL
==================================

// Module: unsigned_seq_array_multiplier
// PURPOSE
//  Parametrised multi-cycle unsigned multiplier. Successor to the 4-bit combinational array multiplier.
//  Generalised operand widths; shift-add of one multiplier bit per clock; optional early exit.
//  Valid/ready handshakes on the operand and result sides.
//  Sits between operand-producing logic and a result consumer in the arithmetic library.
// PARAMETERS
//  WIDTH_A     8   multiplicand (Data_A_In) width, >=2
//  WIDTH_B     8   multiplier (Data_B_In) width, >=2
//  EARLY_EXIT  1   1: finish once remaining multiplier bits are all zero; 0: fixed WIDTH_B cycles
// PORTS
//  Clk_In             in   1                clock, rising edge
//  Reset_n_In         in   1                asynchronous active-low reset
//  Flush_In           in   1                synchronous abort, returns to IDLE
//  In_Valid_In        in   1                operands valid
//  In_Ready_Out       out  1                block can accept operands
//  Data_A_In          in   WIDTH_A          multiplicand
//  Data_B_In          in   WIDTH_B          multiplier
//  Busy_Out           out  1                computation in progress
//  Out_Valid_Out      out  1                product valid
//  Out_Ready_In       in   1                consumer takes product
//  Multiplied_Result_Out out WIDTH_A+WIDTH_B  product
// BEHAVIOUR
//  Reset (async, Reset_n_In=0), effective in any state incl. mid-computation:
//   - state=IDLE; all internal regs cleared.
//   - Outputs: In_Ready_Out=1, Busy_Out=0, Out_Valid_Out=0, Multiplied_Result_Out=0.
//  FSM states IDLE, CALC, DONE:
//   - IDLE: In_Ready_Out=1.
//     - On In_Valid_In&In_Ready_Out edge: latch A (zero-extended to P=WIDTH_A+WIDTH_B), latch B.
//     - Clear acc and count; go to CALC.
//   - CALC: Busy_Out=1, In_Ready_Out=0. Each edge:
//     - if B[0]: acc <= acc + A_sh, P-bit add, no overflow possible.
//     - A_sh <= A_sh<<1; B <= B>>1; count++.
//     - Exit to DONE after the edge where count==WIDTH_B-1, or EARLY_EXIT && (B>>1)==0.
//     - Exit edge loads Multiplied_Result_Out with the final sum.
//   - DONE: Out_Valid_Out=1; result held stable; In_Ready_Out=0.
//     - On Out_Ready_In edge: go to IDLE.
//     - Out_Valid_Out never drops without Out_Ready_In, except on reset or flush.
//  Latency (accept edge -> Out_Valid_Out high), in edges:
//   - EARLY_EXIT=0: WIDTH_B.
//   - EARLY_EXIT=1: max(1, index_of_MSB_set(B)+1); B=0 gives 1.
//  At most one transaction in flight; no operand accepted in CALC or DONE.
//  Multiplied_Result_Out keeps the last product after the DONE->IDLE transition, until the next exit edge.
//  Flush_In=1 on an edge: go to IDLE from any state; acc/count cleared.
//   - Result register is not modified.
//   - Out_Valid_Out=0 next cycle.
//   - Flush has priority over accept and over output handshake on the same edge.
//  Operand inputs are sampled only on the accept edge; later changes are ignored.
//  A_sh is P bits wide so the shifted multiplicand never truncates.
// STRUCTURE
//  Shared package mult_pkg: FSM state encoding (IDLE=2'd0, CALC=2'd1, DONE=2'd2).
//  Also in mult_pkg: function clog2 for count width = clog2(WIDTH_B).
//  Sub-module shift_add_datapath: holds A_sh, B, acc.
//   - Inputs load/step/clear; outputs b_lsb, b_rest_zero, acc.
//  Top level holds the FSM, counter, handshake logic and result register.
// TESTING
//  1 Reset mid-CALC (8x8, A=200,B=255, reset at 3rd CALC edge):
//    all outputs at reset values immediately; next op A=3,B=5 gives 15.
//  2 EARLY_EXIT=0, 8x8:
//    A=255,B=255 gives 65025, Out_Valid_Out exactly 8 edges after accept; A=0,B=0 gives 0 after 8 edges.
//  3 EARLY_EXIT=1, 8x8:
//    A=7,B=0 gives 0 at latency 1; A=7,B=4 gives 28 at latency 3; A=7,B=128 gives 896 at latency 8.
//  4 Back-pressure: hold Out_Ready_In=0 for 5 cycles after Out_Valid_Out.
//    Result and valid stable; In_Ready_Out=0; In_Valid_In pulses are ignored.
//  5 Flush: Flush_In during CALC and during DONE, each time with In_Valid_In=1 on the same edge.
//    State goes to IDLE, Out_Valid_Out=0, operands not accepted that edge.
//  6 Asymmetric WIDTH_A=12,WIDTH_B=4: A=4095,B=15 gives 61425 (16-bit); random 1000-op check vs A*B model.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   state_e : FSM state encoding (IDLE, CALC, DONE)
//   clog2   : ceiling log2, never below 1, used to size the step counter
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bits needed to count 0..value-1; at least one bit so a counter always exists.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) begin
      result = result + 1;
    end
    return (result == 0) ? 1 : result;
  endfunction

endpackage

// File: rtl/shift_add_datapath.sv
// Operand/partial-product registers for the shift-add multiplier.
//   clk, rst_n        : clock, async active-low reset
//   load              : capture operands, clear accumulator
//   step              : take one multiplier bit (acc <= sum_in, shift A left, B right)
//   clear             : abort, clear all registers
//   a_in, b_in        : multiplicand / multiplier
//   sum_in            : next accumulator value computed by the owner of the adder
//   b_lsb             : current multiplier bit
//   b_rest_zero       : all multiplier bits above the current one are zero
//   acc, a_sh         : accumulator and shifted multiplicand
module shift_add_datapath #(
  parameter int unsigned WIDTH_A = 8,
  parameter int unsigned WIDTH_B = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load,
  input  logic                         step,
  input  logic                         clear,
  input  logic [WIDTH_A-1:0]           a_in,
  input  logic [WIDTH_B-1:0]           b_in,
  input  logic [WIDTH_A+WIDTH_B-1:0]   sum_in,
  output logic                         b_lsb,
  output logic                         b_rest_zero,
  output logic [WIDTH_A+WIDTH_B-1:0]   acc,
  output logic [WIDTH_A+WIDTH_B-1:0]   a_sh
);

  localparam int unsigned P = WIDTH_A + WIDTH_B;

  logic [P-1:0]       acc_q;
  logic [P-1:0]       a_sh_q;
  logic [WIDTH_B-1:0] b_q;

  // A_sh is full product width so the shifted multiplicand never truncates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      a_sh_q <= '0;
      b_q    <= '0;
    end else if (clear) begin
      acc_q  <= '0;
      a_sh_q <= '0;
      b_q    <= '0;
    end else if (load) begin
      acc_q  <= '0;
      a_sh_q <= P'(a_in);
      b_q    <= b_in;
    end else if (step) begin
      acc_q  <= sum_in;
      a_sh_q <= a_sh_q << 1;
      b_q    <= b_q >> 1;
    end
  end

  assign b_lsb       = b_q[0];
  assign b_rest_zero = ~|b_q[WIDTH_B-1:1];
  assign acc         = acc_q;
  assign a_sh        = a_sh_q;

endmodule

// File: rtl/unsigned_seq_array_multiplier.sv
// Multi-cycle unsigned multiplier, one multiplier bit per clock, valid/ready on both sides.
//   Clk_In, Reset_n_In      : clock, async active-low reset
//   Flush_In                : synchronous abort back to IDLE (result register untouched)
//   In_Valid_In/In_Ready_Out: operand handshake
//   Data_A_In, Data_B_In    : multiplicand / multiplier
//   Busy_Out                : computation in progress
//   Out_Valid_Out/Out_Ready_In: result handshake
//   Multiplied_Result_Out   : product, held until the next completed computation
module unsigned_seq_array_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH_A    = 8,
  parameter int unsigned WIDTH_B    = 8,
  parameter int unsigned EARLY_EXIT = 1
) (
  input  logic                       Clk_In,
  input  logic                       Reset_n_In,
  input  logic                       Flush_In,
  input  logic                       In_Valid_In,
  output logic                       In_Ready_Out,
  input  logic [WIDTH_A-1:0]         Data_A_In,
  input  logic [WIDTH_B-1:0]         Data_B_In,
  output logic                       Busy_Out,
  output logic                       Out_Valid_Out,
  input  logic                       Out_Ready_In,
  output logic [WIDTH_A+WIDTH_B-1:0] Multiplied_Result_Out
);

  localparam int unsigned P     = WIDTH_A + WIDTH_B;
  localparam int unsigned CNT_W = clog2(WIDTH_B);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH_B - 1);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] count_q;
  logic [P-1:0]     result_q;
  logic             in_ready_q;
  logic             busy_q;
  logic             out_valid_q;

  logic             load_c;
  logic             step_c;
  logic             clear_c;
  logic             last_step_c;
  logic             in_ready_d;
  logic             busy_d;
  logic             out_valid_d;

  logic             b_lsb;
  logic             b_rest_zero;
  logic [P-1:0]     acc;
  logic [P-1:0]     a_sh;
  logic [P-1:0]     sum_c;

  shift_add_datapath #(
    .WIDTH_A (WIDTH_A),
    .WIDTH_B (WIDTH_B)
  ) u_datapath (
    .clk         (Clk_In),
    .rst_n       (Reset_n_In),
    .load        (load_c),
    .step        (step_c),
    .clear       (clear_c),
    .a_in        (Data_A_In),
    .b_in        (Data_B_In),
    .sum_in      (sum_c),
    .b_lsb       (b_lsb),
    .b_rest_zero (b_rest_zero),
    .acc         (acc),
    .a_sh        (a_sh)
  );

  // Single P-bit adder; cannot overflow since the product fits in P bits.
  assign sum_c = acc + (b_lsb ? a_sh : '0);

  // Last step: counter exhausted, or (early exit) no multiplier bits left after this one.
  assign last_step_c = (count_q == CNT_LAST) || ((EARLY_EXIT != 0) && b_rest_zero);

  // State register.
  always_ff @(posedge Clk_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush wins over accept and result handshake.
  always_comb begin
    state_d = state_q;
    if (Flush_In) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (In_Valid_In)  state_d = ST_CALC;
        ST_CALC: if (last_step_c)  state_d = ST_DONE;
        ST_DONE: if (Out_Ready_In) state_d = ST_IDLE;
        default:                   state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath controls and next values of the registered status outputs.
  always_comb begin
    load_c      = 1'b0;
    step_c      = 1'b0;
    clear_c     = Flush_In;
    in_ready_d  = (state_d == ST_IDLE);
    busy_d      = (state_d == ST_CALC);
    out_valid_d = (state_d == ST_DONE);
    if (!Flush_In) begin
      load_c = (state_q == ST_IDLE) && In_Valid_In;
      step_c = (state_q == ST_CALC);
    end
  end

  // Step counter.
  always_ff @(posedge Clk_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      count_q <= '0;
    end else if (clear_c || load_c || (step_c && last_step_c)) begin
      count_q <= '0;
    end else if (step_c) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // Result register: loaded only on the exit edge, untouched by flush.
  always_ff @(posedge Clk_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      result_q <= '0;
    end else if (step_c && last_step_c) begin
      result_q <= sum_c;
    end
  end

  // Registered handshake/status outputs.
  always_ff @(posedge Clk_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign In_Ready_Out          = in_ready_q;
  assign Busy_Out              = busy_q;
  assign Out_Valid_Out         = out_valid_q;
  assign Multiplied_Result_Out = result_q;

endmodule
